// File: rtl/rx_fifo_pkg.sv
// Shared types and constants for the UART receive-side byte FIFO.
package rx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    RELEASE
  } cap_state_e;

  localparam int unsigned OVF_MAX = 255;

  typedef struct packed {
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

  localparam int ENTRY_W = $bits(rx_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with explicit occupancy count.
module sync_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 9,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; only pointers and count need one,
  // which keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Uninitialised storage is masked while empty so the head reads as zero.
  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/rx_byte_fifo.sv
// Receiver-facing capture FSM with ack, overflow tracking and a byte FIFO.
module rx_byte_fifo
  import rx_fifo_pkg::*;
#(
  parameter  int DEPTH           = 16,
  parameter  bit DROP_PARITY_ERR = 1'b0,
  localparam int CW              = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    Dout,
  input  logic          parityErr,
  input  logic          Receive,
  output logic          ReceiveAck,
  output logic [7:0]    rdData,
  output logic          rdPerr,
  output logic          rdValid,
  input  logic          rdReady,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          overflow,
  output logic [7:0]    ovfCount,
  input  logic          clrOvf
);

  cap_state_e state;
  cap_state_e state_next;
  rx_entry_t  wr_entry;
  rx_entry_t  rd_entry;
  logic       empty;
  logic       capture;
  logic       drop_perr;
  logic       pop;
  logic       push;
  logic       ovf_event;

  assign capture   = (state == IDLE) && Receive;
  assign drop_perr = DROP_PARITY_ERR && parityErr;
  assign pop       = rdValid && rdReady;
  assign push      = capture && !drop_perr && (!full || pop);
  assign ovf_event = capture && !drop_perr && full && !pop;
  assign wr_entry  = '{perr: parityErr, data: Dout};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: the default assignment up front keeps this block latch-free.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Receive) state_next = ACK;
      ACK:     state_next = RELEASE;
      // Holding here until Receive drops stops a lingering request being
      // captured twice.
      RELEASE: if (!Receive) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) ReceiveAck <= 1'b0;
    else     ReceiveAck <= capture;
  end

  // A clear in the same cycle as a drop wins; that drop goes uncounted.
  always_ff @(posedge clk) begin
    if (rst || clrOvf) begin
      overflow <= 1'b0;
      ovfCount <= '0;
    end else if (ovf_event) begin
      overflow <= 1'b1;
      if (ovfCount != 8'(OVF_MAX)) ovfCount <= ovfCount + 8'd1;
    end
  end

  sync_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata(wr_entry),
    .pop  (pop),
    .rdata(rd_entry),
    .full (full),
    .empty(empty),
    .count(count)
  );

  assign rdValid = !empty;
  assign rdData  = rd_entry.data;
  assign rdPerr  = rd_entry.perr;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Directed bench for rx_byte_fifo; a second instance drops parity-error bytes.
module tb_rx_byte_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    Dout = '0;
  logic          parityErr = 1'b0;
  logic          Receive = 1'b0;
  logic          rdReady = 1'b0;
  logic          clrOvf = 1'b0;

  logic          ReceiveAck, rdPerr, rdValid, full, overflow;
  logic [7:0]    rdData, ovfCount;
  logic [CW-1:0] count;

  logic          ack_d, perr_d, valid_d, full_d, ovf_d;
  logic [7:0]    data_d, ovfcnt_d;
  logic [CW-1:0] count_d;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rx_byte_fifo #(.DEPTH(DEPTH), .DROP_PARITY_ERR(1'b0)) dut (
    .clk(clk), .rst(rst), .Dout(Dout), .parityErr(parityErr), .Receive(Receive),
    .ReceiveAck(ReceiveAck), .rdData(rdData), .rdPerr(rdPerr), .rdValid(rdValid),
    .rdReady(rdReady), .count(count), .full(full), .overflow(overflow),
    .ovfCount(ovfCount), .clrOvf(clrOvf)
  );

  rx_byte_fifo #(.DEPTH(DEPTH), .DROP_PARITY_ERR(1'b1)) dut_drop (
    .clk(clk), .rst(rst), .Dout(Dout), .parityErr(parityErr), .Receive(Receive),
    .ReceiveAck(ack_d), .rdData(data_d), .rdPerr(perr_d), .rdValid(valid_d),
    .rdReady(rdReady), .count(count_d), .full(full_d), .overflow(ovf_d),
    .ovfCount(ovfcnt_d), .clrOvf(clrOvf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behaves like the UART receiver: holds Receive until the ack, then drops
  // it one cycle later (plus extra_hold cycles).
  task automatic send_byte(input logic [7:0] d, input logic p, input int extra_hold,
                           input logic pop_same, input logic clr_same);
    int lat;
    @(negedge clk);
    Receive = 1'b1; Dout = d; parityErr = p; rdReady = pop_same; clrOvf = clr_same;
    lat = 0;
    do begin
      @(negedge clk);
      rdReady = 1'b0; clrOvf = 1'b0;
      lat++;
    end while (!ReceiveAck && lat < 4);
    check("ack_latency", lat, 1);
    check("ack_drop_inst", ack_d, 1'b1);
    @(negedge clk);
    check("ack_one_cycle", ReceiveAck, 1'b0);
    repeat (extra_hold) @(negedge clk);
    Receive = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_expect(input logic [7:0] d, input logic p);
    @(negedge clk);
    check("pop_valid", rdValid, 1'b1);
    check("pop_data", rdData, d);
    check("pop_perr", rdPerr, p);
    rdReady = 1'b1;
    @(negedge clk);
    rdReady = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack", ReceiveAck, 1'b0);
    check("rst_count", count, 0);
    check("rst_valid", rdValid, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_ovfcnt", ovfCount, 0);
    check("rst_data", rdData, 0);
    check("rst_perr", rdPerr, 1'b0);
    rst = 1'b0;

    // Single byte, Receive lingering two extra cycles must not double-capture
    send_byte(8'hA5, 1'b0, 2, 1'b0, 1'b0);
    check("single_valid", rdValid, 1'b1);
    check("single_data", rdData, 8'hA5);
    check("single_perr", rdPerr, 1'b0);
    check("single_count", count, 1);
    @(negedge clk);
    check("hold_data", rdData, 8'hA5);
    pop_expect(8'hA5, 1'b0);
    check("drain_count", count, 0);
    check("drain_valid", rdValid, 1'b0);

    // Fill past full: 0x10 is dropped
    for (int i = 0; i <= 16; i++) send_byte(8'(i), 1'b0, 0, 1'b0, 1'b0);
    check("fill_full", full, 1'b1);
    check("fill_count", count, 16);
    check("fill_ovf", overflow, 1'b1);
    check("fill_ovfcnt", ovfCount, 1);
    check("fill_count_drop_inst", count_d, 16);

    // Full with a pop in the capture cycle: 0x55 goes in, no overflow
    @(negedge clk);
    check("full_head", rdData, 8'h00);
    send_byte(8'h55, 1'b0, 0, 1'b1, 1'b0);
    check("fullpop_count", count, 16);
    check("fullpop_ovfcnt", ovfCount, 1);
    check("fullpop_head", rdData, 8'h01);
    for (int i = 1; i <= 15; i++) pop_expect(8'(i), 1'b0);
    pop_expect(8'h55, 1'b0);
    check("fullpop_empty", rdValid, 1'b0);

    // Plain clear
    @(negedge clk); clrOvf = 1'b1;
    @(negedge clk); clrOvf = 1'b0;
    check("clr_ovf", overflow, 1'b0);
    check("clr_ovfcnt", ovfCount, 0);

    // Parity error byte: stored in one instance, dropped in the other
    send_byte(8'h3C, 1'b1, 0, 1'b0, 1'b0);
    check("perr_count", count, 1);
    check("perr_data", rdData, 8'h3C);
    check("perr_flag", rdPerr, 1'b1);
    check("perr_drop_count", count_d, 0);
    check("perr_drop_ovf", ovf_d, 1'b0);
    pop_expect(8'h3C, 1'b1);
    check("pop_empty_ignored", count_d, 0);

    // Reset while in ACK
    @(negedge clk);
    Receive = 1'b1; Dout = 8'h77; parityErr = 1'b0;
    @(negedge clk);
    check("ackstate_ack", ReceiveAck, 1'b1);
    check("ackstate_count", count, 1);
    rst = 1'b1; Receive = 1'b0;
    @(negedge clk);
    check("midrst_ack", ReceiveAck, 1'b0);
    check("midrst_count", count, 0);
    check("midrst_valid", rdValid, 1'b0);
    check("midrst_full", full, 1'b0);
    check("midrst_ovf", overflow, 1'b0);
    check("midrst_ovfcnt", ovfCount, 0);
    check("midrst_data", rdData, 0);
    check("midrst_perr", rdPerr, 1'b0);
    // Receive asserted during reset must not be written
    Receive = 1'b1; Dout = 8'h99;
    @(negedge clk);
    check("rstrx_count", count, 0);
    check("rstrx_ack", ReceiveAck, 1'b0);
    rst = 1'b0; Receive = 1'b0;
    send_byte(8'h42, 1'b0, 0, 1'b0, 1'b0);
    check("post_rst_data", rdData, 8'h42);
    check("post_rst_count", count, 1);
    pop_expect(8'h42, 1'b0);

    // 16 stored bytes, then 300 drops saturate the counter
    for (int i = 0; i < 16; i++) send_byte(8'(8'hC0 + i), 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) send_byte(8'hEE, 1'b0, 0, 1'b0, 1'b0);
    check("sat_ovf", overflow, 1'b1);
    check("sat_ovfcnt", ovfCount, 255);
    check("sat_count", count, 16);
    check("sat_head", rdData, 8'hC0);

    // Clear coincides with a drop: the clear wins
    send_byte(8'hEE, 1'b0, 0, 1'b0, 1'b1);
    check("clrwin_ovf", overflow, 1'b0);
    check("clrwin_ovfcnt", ovfCount, 0);
    send_byte(8'hEE, 1'b0, 0, 1'b0, 1'b0);
    check("redrop_ovf", overflow, 1'b1);
    check("redrop_ovfcnt", ovfCount, 1);
    @(negedge clk); clrOvf = 1'b1;
    @(negedge clk); clrOvf = 1'b0;
    check("final_clr_ovf", overflow, 1'b0);
    check("final_clr_ovfcnt", ovfCount, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
